// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester round-robin / fixed-priority arbiter.
package arb_pkg;

    localparam int unsigned REQ_N = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/codpri4.sv
// 4:2 priority encoder: index of the highest set input bit, zero when disabled or empty.
module codpri4
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [REQ_N-1:0] din,
    output logic [ID_W-1:0]  idx_c
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx_c = '0;
        if (en) begin
            for (int unsigned i = 0; i < REQ_N; i++) begin
                if (din[i]) begin
                    idx_c = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/arbitro_rr4.sv
// Single-resource arbiter for 4 requesters: fixed priority or downward round-robin,
// grant held until the owner drops its request or MAX_HOLD cycles elapse.
module arbitro_rr4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req,
    input  logic             rr,
    output logic [REQ_N-1:0] grant,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    last;

    logic [REQ_N-1:0]   low_mask;
    logic [REQ_N-1:0]   masked;
    logic [ID_W-1:0]    masked_id;
    logic [ID_W-1:0]    req_id;
    logic [ID_W-1:0]    win;

    // Requesters strictly below the previous winner get first pick in round-robin.
    assign low_mask = (REQ_N'(1) << last) - REQ_N'(1);
    assign masked   = req & low_mask;

    codpri4 u_enc_masked (
        .en    (rr),
        .din   (masked),
        .idx_c (masked_id)
    );

    codpri4 u_enc_req (
        .en    (1'b1),
        .din   (req),
        .idx_c (req_id)
    );

    assign win = (rr && (masked != '0)) ? masked_id : req_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last    <= '0;
            grant   <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (req != '0) begin
                        state  <= ST_GRANT;
                        grant  <= REQ_N'(1) << win;
                        gnt_id <= win;
                        busy   <= 1'b1;
                        cnt    <= CNT_W'(1);
                        last   <= win;
                    end
                end
                ST_GRANT: begin
                    if (!req[gnt_id] || (cnt == CNT_W'(MAX_HOLD))) begin
                        // Any release returns to IDLE, which forces a dead cycle.
                        state   <= ST_IDLE;
                        grant   <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        timeout <= req[gnt_id];
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant   <= '0;
                    gnt_id  <= '0;
                    busy    <= 1'b0;
                    cnt     <= '0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule
